// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: request opcodes, response
// status codes and the controller state encoding seen by the UI front end.
package atm_pkg;

  localparam logic [2:0] OP_LOGIN      = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [2:0] OP_EXIT       = 3'd5;

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_BAD_PIN      = 3'd1;
  localparam logic [2:0] ST_NO_ACCOUNT   = 3'd2;
  localparam logic [2:0] ST_LOCKED       = 3'd3;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
  localparam logic [2:0] ST_OVERFLOW     = 3'd5;
  localparam logic [2:0] ST_BAD_SEQ      = 3'd6;
  localparam logic [2:0] ST_TIMEOUT      = 3'd7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SESSION = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Request/response channel between the UI front end (master) and the
// session controller (slave).
interface atm_session_ctrl_if #(
  parameter int ACC_W = 4,
  parameter int BAL_W = 16,
  parameter int PIN_W = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [ACC_W-1:0] req_acc;
  logic [PIN_W-1:0] req_pin;
  logic [PIN_W-1:0] req_new_pin;
  logic [BAL_W-1:0] req_amount;
  logic             rsp_valid;
  logic [2:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;

  modport master (
    output req_valid, req_op, req_acc, req_pin, req_new_pin, req_amount,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_acc, req_pin, req_new_pin, req_amount,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );

endinterface

// File: rtl/atm_account_store.sv
// Per-account balance, PIN, bad-PIN counter and lock bit, with one
// combinational read port and one full-record write port.
module atm_account_store #(
  parameter int               NUM_ACCOUNTS = 10,
  parameter int               ACC_W        = 4,
  parameter int               BAL_W        = 16,
  parameter int               PIN_W        = 16,
  parameter int               FAIL_W       = 2,
  parameter logic [BAL_W-1:0] INIT_BAL     = 16'd500,
  parameter logic [PIN_W-1:0] INIT_PIN     = 16'h1234
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ACC_W-1:0]  rd_acc,
  output logic [BAL_W-1:0]  rd_bal,
  output logic [PIN_W-1:0]  rd_pin,
  output logic [FAIL_W-1:0] rd_fail,
  output logic              rd_lock,
  input  logic              wr_en,
  input  logic [ACC_W-1:0]  wr_acc,
  input  logic [BAL_W-1:0]  wr_bal,
  input  logic [PIN_W-1:0]  wr_pin,
  input  logic [FAIL_W-1:0] wr_fail,
  input  logic              wr_lock
);

  logic [BAL_W-1:0]  bal_r  [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  pin_r  [NUM_ACCOUNTS];
  logic [FAIL_W-1:0] fail_r [NUM_ACCOUNTS];
  logic              lock_r [NUM_ACCOUNTS];
  logic              rd_ok_s;
  logic              wr_ok_s;

  // Out-of-range account numbers read as zero and never write.
  assign rd_ok_s = ({1'b0, rd_acc} < (ACC_W+1)'(NUM_ACCOUNTS));
  assign wr_ok_s = ({1'b0, wr_acc} < (ACC_W+1)'(NUM_ACCOUNTS));

  // Account record storage with reset-time initialisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_r[i]  <= INIT_BAL;
        pin_r[i]  <= INIT_PIN + PIN_W'(i);
        fail_r[i] <= '0;
        lock_r[i] <= 1'b0;
      end
    end else if (wr_en && wr_ok_s) begin
      bal_r[wr_acc]  <= wr_bal;
      pin_r[wr_acc]  <= wr_pin;
      fail_r[wr_acc] <= wr_fail;
      lock_r[wr_acc] <= wr_lock;
    end
  end

  // Combinational read port.
  always_comb begin
    rd_bal  = '0;
    rd_pin  = '0;
    rd_fail = '0;
    rd_lock = 1'b0;
    if (rd_ok_s) begin
      rd_bal  = bal_r[rd_acc];
      rd_pin  = pin_r[rd_acc];
      rd_fail = fail_r[rd_acc];
      rd_lock = lock_r[rd_acc];
    end else begin
      rd_lock = 1'b0;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: login with PIN lockout, per-session account ops,
// inactivity timeout, and a one-cycle registered response.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS   = 10,
  parameter int               BAL_W          = 16,
  parameter int               PIN_W          = 16,
  parameter logic [BAL_W-1:0] INIT_BAL       = 16'd500,
  parameter logic [PIN_W-1:0] INIT_PIN       = 16'h1234,
  parameter int               MAX_TRIES      = 3,
  parameter int               TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  atm_session_ctrl_if.slave bus,
  output logic [2:0]        current_state
);

  localparam int ACC_W  = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]        state_r, ret_state_r, ret_state_s;
  logic              ready_r, from_sess_r, accept_s, acc_ok_s;
  logic [2:0]        op_r;
  logic [ACC_W-1:0]  acc_r, sess_acc_r, new_sess_acc_s, rd_acc_s;
  logic [PIN_W-1:0]  pin_r, new_pin_r;
  logic [BAL_W-1:0]  amount_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              rsp_valid_r;
  logic [2:0]        rsp_status_r, exec_status_s;
  logic [BAL_W-1:0]  rsp_bal_r, exec_bal_s;
  logic [BAL_W:0]    sum_s;
  logic [BAL_W-1:0]  rd_bal_s, wr_bal_s;
  logic [PIN_W-1:0]  rd_pin_s, wr_pin_s;
  logic [FAIL_W-1:0] rd_fail_s, wr_fail_s, fail_next_s;
  logic              rd_lock_s, wr_lock_s, wr_en_s;

  assign accept_s      = bus.req_valid & ready_r;
  assign rd_acc_s      = from_sess_r ? sess_acc_r : acc_r;
  assign acc_ok_s      = ({1'b0, acc_r} < (ACC_W+1)'(NUM_ACCOUNTS));
  assign sum_s         = {1'b0, rd_bal_s} + {1'b0, amount_r};
  assign bus.req_ready   = ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_status  = rsp_status_r;
  assign bus.rsp_balance = rsp_bal_r;
  assign current_state   = state_r;

  atm_account_store #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACC_W        (ACC_W),
    .BAL_W        (BAL_W),
    .PIN_W        (PIN_W),
    .FAIL_W       (FAIL_W),
    .INIT_BAL     (INIT_BAL),
    .INIT_PIN     (INIT_PIN)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_acc  (rd_acc_s),
    .rd_bal  (rd_bal_s),
    .rd_pin  (rd_pin_s),
    .rd_fail (rd_fail_s),
    .rd_lock (rd_lock_s),
    .wr_en   (wr_en_s & (state_r == S_EXEC)),
    .wr_acc  (rd_acc_s),
    .wr_bal  (wr_bal_s),
    .wr_pin  (wr_pin_s),
    .wr_fail (wr_fail_s),
    .wr_lock (wr_lock_s)
  );

  // Execute the captured request against the addressed account record.
  always_comb begin
    exec_status_s  = ST_BAD_SEQ;
    exec_bal_s     = '0;
    ret_state_s    = from_sess_r ? S_SESSION : S_IDLE;
    new_sess_acc_s = sess_acc_r;
    wr_en_s        = 1'b0;
    wr_bal_s       = rd_bal_s;
    wr_pin_s       = rd_pin_s;
    wr_fail_s      = rd_fail_s;
    wr_lock_s      = rd_lock_s;
    fail_next_s    = (rd_fail_s >= FAIL_W'(MAX_TRIES)) ? rd_fail_s : rd_fail_s + FAIL_W'(1);
    if (!from_sess_r) begin
      if (op_r != OP_LOGIN) begin
        exec_status_s = ST_BAD_SEQ;
      end else if (!acc_ok_s) begin
        exec_status_s = ST_NO_ACCOUNT;
      end else if (rd_lock_s) begin
        exec_status_s = ST_LOCKED;
      end else if (pin_r != rd_pin_s) begin
        exec_status_s = ST_BAD_PIN;
        wr_en_s       = 1'b1;
        wr_fail_s     = fail_next_s;
        wr_lock_s     = (fail_next_s >= FAIL_W'(MAX_TRIES));
      end else begin
        exec_status_s  = ST_OK;
        exec_bal_s     = rd_bal_s;
        wr_en_s        = 1'b1;
        wr_fail_s      = '0;
        ret_state_s    = S_SESSION;
        new_sess_acc_s = acc_r;
      end
    end else begin
      case (op_r)
        OP_BALANCE: begin
          exec_status_s = ST_OK;
          exec_bal_s    = rd_bal_s;
        end
        OP_WITHDRAW: begin
          if (amount_r > rd_bal_s) begin
            exec_status_s = ST_INSUFFICIENT;
          end else begin
            exec_status_s = ST_OK;
            wr_en_s       = 1'b1;
            wr_bal_s      = rd_bal_s - amount_r;
            exec_bal_s    = wr_bal_s;
          end
        end
        OP_DEPOSIT: begin
          if (sum_s[BAL_W]) begin
            exec_status_s = ST_OVERFLOW;
          end else begin
            exec_status_s = ST_OK;
            wr_en_s       = 1'b1;
            wr_bal_s      = sum_s[BAL_W-1:0];
            exec_bal_s    = wr_bal_s;
          end
        end
        OP_CHANGE_PIN: begin
          exec_status_s = ST_OK;
          exec_bal_s    = rd_bal_s;
          wr_en_s       = 1'b1;
          wr_pin_s      = new_pin_r;
        end
        OP_EXIT: begin
          exec_status_s = ST_OK;
          exec_bal_s    = rd_bal_s;
          ret_state_s   = S_IDLE;
        end
        default: begin
          exec_status_s = ST_BAD_SEQ;
        end
      endcase
    end
  end

  // Sequencing, request capture, inactivity timer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      ret_state_r  <= S_IDLE;
      ready_r      <= 1'b1;
      from_sess_r  <= 1'b0;
      op_r         <= 3'd0;
      acc_r        <= '0;
      sess_acc_r   <= '0;
      pin_r        <= '0;
      new_pin_r    <= '0;
      amount_r     <= '0;
      to_cnt_r     <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= ST_OK;
      rsp_bal_r    <= '0;
    end else begin
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= ST_OK;
      rsp_bal_r    <= '0;
      case (state_r)
        S_IDLE, S_SESSION: begin
          if (accept_s) begin
            op_r        <= bus.req_op;
            acc_r       <= bus.req_acc;
            pin_r       <= bus.req_pin;
            new_pin_r   <= bus.req_new_pin;
            amount_r    <= bus.req_amount;
            from_sess_r <= (state_r == S_SESSION);
            to_cnt_r    <= '0;
            ready_r     <= 1'b0;
            state_r     <= S_EXEC;
          end else if (state_r != S_SESSION) begin
            to_cnt_r <= '0;
          end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Idle session expired: forced logout with a timeout strobe.
            to_cnt_r     <= '0;
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= ST_TIMEOUT;
            state_r      <= S_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        S_EXEC: begin
          rsp_valid_r  <= 1'b1;
          rsp_status_r <= exec_status_s;
          rsp_bal_r    <= exec_bal_s;
          ret_state_r  <= ret_state_s;
          sess_acc_r   <= new_sess_acc_s;
          state_r      <= S_RESP;
        end
        S_RESP: begin
          ready_r <= 1'b1;
          state_r <= ret_state_r;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
